exposure_sequencer: RTL and testbench

- Per-frame exposure scheduler that sits in front of the frame timing controller and drives its EXPOSURE_0/1/2 and STROBE_WIDTH configuration inputs.
- Holds a small programmable table of exposure profiles for HDR bracketing.
- Steps through the table one profile per exposure, and only changes outputs while no exposure is in progress.
- Supports continuous looping or one-shot sequences; outside sequencing it passes static register values through.

---
 rtl/exposure_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_exposure_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_sequencer.sv
// -----------------------------------------------------------------------------
// exposure_sequencer
//
// Per-frame exposure scheduler placed in front of the frame timing controller.
// A small table of exposure profiles (three exposure times plus a strobe width
// per entry) is stepped through one entry per exposure for HDR bracketing.
// The configuration outputs only change while no exposure is in progress.
// Outside sequencing the static register values are passed through.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   cfg_wr_en/addr/data   table write port; addr = {entry, word}, word 0..2 =
//                         exposure 0..2, word 3 = strobe width
//   seq_enable            level: 1 = sequence the table, 0 = static values
//   seq_oneshot           stop after one pass (latched when a sequence starts)
//   seq_length            entries in use (0 -> 1, above DEPTH -> DEPTH)
//   static_*              values driven while idle
//   exposure_active       exposure-in-progress level from the timing controller
//   exp_0/1/2, strobe_width  registered configuration to the timing controller
//   seq_index             entry currently presented
//   seq_busy              sequencer not idle
//   seq_wrap              1-cycle pulse when the index wraps to 0
//   seq_done              1-cycle pulse when a one-shot pass completes
//   pass_count            completed passes since enable (wraps mod 2^16)
// -----------------------------------------------------------------------------
module exposure_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          cfg_wr_en,
    input  logic [AW+1:0] cfg_wr_addr,
    input  logic [31:0]   cfg_wr_data,
    input  logic          seq_enable,
    input  logic          seq_oneshot,
    input  logic [AW:0]   seq_length,
    input  logic [31:0]   static_exp0,
    input  logic [31:0]   static_exp1,
    input  logic [31:0]   static_exp2,
    input  logic [31:0]   static_strobe_width,
    input  logic          exposure_active,
    output logic [31:0]   exp_0,
    output logic [31:0]   exp_1,
    output logic [31:0]   exp_2,
    output logic [31:0]   strobe_width,
    output logic [AW-1:0] seq_index,
    output logic          seq_busy,
    output logic          seq_wrap,
    output logic          seq_done,
    output logic [15:0]   pass_count
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_RUN
    } state_t;

    state_t        state_q, state_nx;

    logic [31:0]   table_mem [DEPTH*4];

    logic          exp_q;       // exposure_active delayed by one cycle
    logic          rise, fall;
    logic [AW-1:0] index_q;     // entry to be loaded next
    logic [AW:0]   len_q;       // effective length sampled at the last LOAD
    logic [AW:0]   len_eff;
    logic          oneshot_q;
    logic          done_q;      // one-shot pass finished, leave on next fall
    logic          is_last;

    logic          start, load_static, load_entry, advance, finish;

    assign rise     = exposure_active & ~exp_q;
    assign fall     = ~exposure_active & exp_q;
    assign seq_busy = (state_q != S_IDLE);

    // Comparing with >= also catches an index left beyond a newly shortened
    // length, which then wraps to 0 like a normal end of pass.
    assign is_last  = ({1'b0, index_q} >= (len_q - LEN_ONE));

    always_comb begin
        len_eff = seq_length;
        if (seq_length == '0) begin
            len_eff = LEN_ONE;
        end else if (seq_length > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
    end

    // NOTE: the profile table has no reset; a memory array under reset cannot
    // map onto RAM, and its contents are only meaningful once software writes them.
    always_ff @(posedge aclk) begin
        if (cfg_wr_en) begin
            table_mem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state_q;
        start      = 1'b0;
        load_entry = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (seq_enable && !exposure_active) begin
                    start    = 1'b1;
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                // Hold off presenting a new entry until no exposure is running.
                if (!exposure_active) begin
                    load_entry = 1'b1;
                    state_nx   = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!seq_enable) begin
                    state_nx = S_IDLE;
                end else if (rise) begin
                    advance  = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (fall) begin
                    if (done_q) begin
                        finish   = 1'b1;
                        state_nx = S_IDLE;
                    end else if (!seq_enable) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Static values are loaded on the edge that enters or stays in IDLE, so
    // they appear the cycle after leaving a sequence, but never mid-exposure.
    assign load_static = (state_nx == S_IDLE) && !exposure_active;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            exp_q        <= 1'b0;
            index_q      <= '0;
            len_q        <= '0;
            oneshot_q    <= 1'b0;
            done_q       <= 1'b0;
            exp_0        <= '0;
            exp_1        <= '0;
            exp_2        <= '0;
            strobe_width <= '0;
            seq_index    <= '0;
            seq_wrap     <= 1'b0;
            seq_done     <= 1'b0;
            pass_count   <= '0;
        end else begin
            exp_q    <= exposure_active;
            seq_wrap <= 1'b0;
            seq_done <= 1'b0;

            if (start) begin
                index_q    <= '0;
                pass_count <= '0;
                oneshot_q  <= seq_oneshot;
                done_q     <= 1'b0;
            end

            if (load_static) begin
                exp_0        <= static_exp0;
                exp_1        <= static_exp1;
                exp_2        <= static_exp2;
                strobe_width <= static_strobe_width;
                seq_index    <= '0;
            end

            // Registered table read: a write to the same entry on this edge is
            // not visible until that entry is loaded again.
            if (load_entry) begin
                exp_0        <= table_mem[{index_q, 2'd0}];
                exp_1        <= table_mem[{index_q, 2'd1}];
                exp_2        <= table_mem[{index_q, 2'd2}];
                strobe_width <= table_mem[{index_q, 2'd3}];
                seq_index    <= index_q;
                len_q        <= len_eff;
            end

            if (advance) begin
                if (is_last) begin
                    index_q    <= '0;
                    seq_wrap   <= 1'b1;
                    pass_count <= pass_count + 16'd1;
                    if (oneshot_q) begin
                        done_q <= 1'b1;
                    end
                end else begin
                    index_q <= index_q + 1'b1;
                end
            end

            if (finish) begin
                seq_done <= 1'b1;
                done_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exposure_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exposure_sequencer
//
// Self-checking bench for exposure_sequencer. The reference model tracks the
// table contents in an array and the sequence position as plain integers
// (index, completed passes), advancing them once per exposure pulse.
// -----------------------------------------------------------------------------
module tb_exposure_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          aclk;
    logic          aresetn;
    logic          cfg_wr_en;
    logic [AW+1:0] cfg_wr_addr;
    logic [31:0]   cfg_wr_data;
    logic          seq_enable;
    logic          seq_oneshot;
    logic [AW:0]   seq_length;
    logic [31:0]   static_exp0, static_exp1, static_exp2, static_strobe_width;
    logic          exposure_active;
    logic [31:0]   exp_0, exp_1, exp_2, strobe_width;
    logic [AW-1:0] seq_index;
    logic          seq_busy, seq_wrap, seq_done;
    logic [15:0]   pass_count;

    exposure_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .cfg_wr_en           (cfg_wr_en),
        .cfg_wr_addr         (cfg_wr_addr),
        .cfg_wr_data         (cfg_wr_data),
        .seq_enable          (seq_enable),
        .seq_oneshot         (seq_oneshot),
        .seq_length          (seq_length),
        .static_exp0         (static_exp0),
        .static_exp1         (static_exp1),
        .static_exp2         (static_exp2),
        .static_strobe_width (static_strobe_width),
        .exposure_active     (exposure_active),
        .exp_0               (exp_0),
        .exp_1               (exp_1),
        .exp_2               (exp_2),
        .strobe_width        (strobe_width),
        .seq_index           (seq_index),
        .seq_busy            (seq_busy),
        .seq_wrap            (seq_wrap),
        .seq_done            (seq_done),
        .pass_count          (pass_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters, sampled on the rising edge (each pulse spans one cycle).
    int wrap_cnt = 0;
    int done_cnt = 0;
    always @(posedge aclk) begin
        if (seq_wrap) wrap_cnt <= wrap_cnt + 1;
        if (seq_done) done_cnt <= done_cnt + 1;
    end

    // Reference model state.
    logic [31:0] m_tbl [DEPTH*4];
    int          m_idx;
    int          m_pass;
    int          m_eff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    function automatic int eff_len(input int len);
        if (len == 0) return 1;
        if (len > DEPTH) return DEPTH;
        return len;
    endfunction

    task automatic wr(input int entry, input int word, input logic [31:0] data);
        logic [AW-1:0] e;
        logic [1:0]    w;
        e = entry[AW-1:0];
        w = word[1:0];
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = {e, w};
        cfg_wr_data = data;
        m_tbl[entry*4 + word] = data;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic check_presented();
        int b;
        b = m_idx * 4;
        check("exp0",   exp_0,        m_tbl[b]);
        check("exp1",   exp_1,        m_tbl[b+1]);
        check("exp2",   exp_2,        m_tbl[b+2]);
        check("strobe", strobe_width, m_tbl[b+3]);
        check("index",  seq_index,    m_idx);
    endtask

    task automatic check_static();
        check("st_exp0",   exp_0,        static_exp0);
        check("st_exp1",   exp_1,        static_exp1);
        check("st_exp2",   exp_2,        static_exp2);
        check("st_strobe", strobe_width, static_strobe_width);
        check("st_busy",   seq_busy,     1'b0);
    endtask

    // Enable from IDLE; new outputs are expected two edges after the enable.
    task automatic start_seq(input int len, input bit oneshot);
        seq_length  = len[AW:0];
        seq_oneshot = oneshot;
        seq_enable  = 1'b1;
        m_eff  = eff_len(len);
        m_idx  = 0;
        m_pass = 0;
        tick();
        tick();
        check("start_busy", seq_busy, 1'b1);
        check_presented();
    endtask

    // One exposure pulse; returns one cycle after the falling edge is seen.
    task automatic exposure(input int hold, input bit rewrite, input logic [31:0] rw_val);
        logic [31:0] old0;
        int          w0;
        bit          exp_wrap;
        check_presented();
        old0     = m_tbl[m_idx*4];
        w0       = wrap_cnt;
        exp_wrap = (m_idx >= m_eff - 1);
        exposure_active = 1'b1;
        tick();
        if (rewrite) begin
            wr(m_idx, 0, rw_val);
        end
        repeat (hold) tick();
        check("wrap",      wrap_cnt - w0, exp_wrap);
        check("hold_exp0", exp_0,         old0);
        check("run_busy",  seq_busy,      1'b1);
        if (exp_wrap) begin
            m_idx = 0;
            m_pass++;
        end else begin
            m_idx++;
        end
        check("pass", pass_count, m_pass);
        exposure_active = 1'b0;
        tick();
    endtask

    // Leave a continuous sequence from ARMED.
    task automatic stop_seq();
        seq_enable = 1'b0;
        tick();
        tick();
        check_static();
    endtask

    task automatic oneshot_finish(input int d0);
        check_static();
        seq_enable = 1'b0;
        tick();
        tick();
        check("done", done_cnt - d0, 1);
        check("done_idle", seq_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0;
        int w0;
        aresetn             = 1'b0;
        cfg_wr_en           = 1'b0;
        cfg_wr_addr         = '0;
        cfg_wr_data         = '0;
        seq_enable          = 1'b0;
        seq_oneshot         = 1'b0;
        seq_length          = '0;
        static_exp0         = 32'd1000;
        static_exp1         = 32'd1001;
        static_exp2         = 32'd1002;
        static_strobe_width = 32'd5;
        exposure_active     = 1'b0;
        m_idx = 0; m_pass = 0; m_eff = 1;

        // Reset, then static pass-through.
        tick(); tick();
        check("rst_exp0",  exp_0,      32'd0);
        check("rst_busy",  seq_busy,   1'b0);
        check("rst_pass",  pass_count, 16'd0);
        aresetn = 1'b1;
        tick();
        check_static();
        check("st_index", seq_index, 0);

        // Three-entry table, continuous, seven exposures.
        for (int e = 0; e < 3; e++) begin
            wr(e, 0, 32'd100 << e);
            wr(e, 1, 32'd500 + e);
            wr(e, 2, 32'd600 + e);
            wr(e, 3, 32'd10 << e);
        end
        w0 = wrap_cnt;
        start_seq(3, 1'b0);
        for (int p = 0; p < 7; p++) begin
            exposure(3, 1'b0, 32'd0);
            repeat (2) tick();
        end
        check("wrap_total", wrap_cnt - w0, 2);
        check("pass7", pass_count, 16'd2);
        stop_seq();

        // Rewrite entry 1 while it is being exposed.
        start_seq(3, 1'b0);
        exposure(3, 1'b0, 32'd0);
        repeat (2) tick();
        exposure(3, 1'b1, 32'd777);
        repeat (2) tick();
        for (int p = 0; p < 3; p++) begin
            exposure(2, 1'b0, 32'd0);
            repeat (2) tick();
        end
        check("rewritten", m_tbl[4], 32'd777);
        stop_seq();

        // One-shot of two entries.
        d0 = done_cnt;
        start_seq(2, 1'b1);
        exposure(3, 1'b0, 32'd0);
        repeat (2) tick();
        check("no_done_yet", done_cnt - d0, 0);
        exposure(3, 1'b0, 32'd0);
        oneshot_finish(d0);

        // Length 0 behaves as 1; length 12 clamps to 8.
        for (int e = 3; e < DEPTH; e++) begin
            for (int w = 0; w < 4; w++) wr(e, w, 32'(e * 16 + w));
        end
        start_seq(0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            exposure(2, 1'b0, 32'd0);
            repeat (2) tick();
        end
        stop_seq();
        start_seq(12, 1'b0);
        for (int p = 0; p < 10; p++) begin
            exposure(2, 1'b0, 32'd0);
            repeat (2) tick();
        end
        stop_seq();

        // Enable while an exposure is already running.
        seq_length      = 4'd3;
        m_eff           = 3;
        m_idx           = 0;
        m_pass          = 0;
        exposure_active = 1'b1;
        seq_enable      = 1'b1;
        repeat (50) tick();
        check("hold_idle_busy", seq_busy, 1'b0);
        check("hold_idle_exp0", exp_0,    static_exp0);
        exposure_active = 1'b0;
        tick();
        check("load_busy", seq_busy, 1'b1);
        check("load_exp0", exp_0,    static_exp0);
        tick();
        check_presented();
        exposure(3, 1'b0, 32'd0);
        repeat (2) tick();

        // Reset in the middle of an exposure.
        exposure_active = 1'b1;
        repeat (3) tick();
        check("pre_rst_busy", seq_busy, 1'b1);
        aresetn = 1'b0;
        #1;
        check("arst_exp0",   exp_0,        32'd0);
        check("arst_exp1",   exp_1,        32'd0);
        check("arst_exp2",   exp_2,        32'd0);
        check("arst_strobe", strobe_width, 32'd0);
        check("arst_index",  seq_index,    0);
        check("arst_busy",   seq_busy,     1'b0);
        check("arst_wrap",   seq_wrap,     1'b0);
        check("arst_done",   seq_done,     1'b0);
        check("arst_pass",   pass_count,   16'd0);
        exposure_active = 1'b0;
        tick();
        aresetn = 1'b1;
        m_idx  = 0;
        m_pass = 0;
        tick();
        tick();
        check("restart_busy", seq_busy, 1'b1);
        check_presented();
        exposure(2, 1'b0, 32'd0);
        repeat (2) tick();
        stop_seq();

        // Randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            int  len;
            int  npulses;
            bit  os;
            for (int e = 0; e < DEPTH; e++) begin
                for (int w = 0; w < 4; w++) wr(e, w, $urandom);
            end
            static_exp0         = $urandom;
            static_exp1         = $urandom;
            static_exp2         = $urandom;
            static_strobe_width = $urandom;
            tick();
            check_static();
            len = $urandom_range(0, 2*DEPTH - 1);
            os  = 1'($urandom_range(0, 1));
            d0  = done_cnt;
            start_seq(len, os);
            npulses = os ? m_eff : $urandom_range(1, 2*m_eff + 2);
            for (int p = 0; p < npulses; p++) begin
                exposure($urandom_range(2, 6), 1'b0, 32'd0);
                if (!(os && p == npulses - 1)) begin
                    repeat ($urandom_range(1, 4)) tick();
                end
            end
            if (os) begin
                oneshot_finish(d0);
            end else begin
                check("rand_pass", pass_count, 16'(npulses / m_eff));
                stop_seq();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
